// File: rtl/ht_cmd_arbiter.sv
// ht_cmd_arbiter: round-robin sharing of one hash-table command/result port
// between NUM_REQ requesters. Commands pass through one registered stage;
// an in-order tag FIFO remembers which requester issued each command so the
// in-order results can be steered back to the right requester.
`timescale 1ns/1ps
module ht_cmd_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int KEY_WIDTH       = 18,
    parameter int VALUE_WIDTH     = 5,
    parameter int CMD_WIDTH       = KEY_WIDTH + VALUE_WIDTH + 2,
    parameter int RES_WIDTH       = 64,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NUM_REQ*CMD_WIDTH-1:0]       req_cmd_i,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    output logic [NUM_REQ-1:0]                 req_ready_o,
    output logic [CMD_WIDTH-1:0]               ht_cmd_o,
    output logic                               ht_cmd_valid_o,
    input  logic                               ht_cmd_ready_i,
    input  logic [RES_WIDTH-1:0]               ht_res_i,
    input  logic                               ht_res_valid_i,
    output logic                               ht_res_ready_o,
    output logic [RES_WIDTH-1:0]               req_res_o,
    output logic [NUM_REQ-1:0]                 req_res_valid_o,
    input  logic [NUM_REQ-1:0]                 req_res_ready_i,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
    output logic                               err_o
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    // Control state (reset)
    logic [ID_W-1:0]      r_rr_ptr;
    logic                 r_cmd_valid;
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_err;

    // Data state (not reset; qualified by the control state above)
    logic [CMD_WIDTH-1:0] r_cmd;
    logic [ID_W-1:0]      r_tag_mem [MAX_OUTSTANDING];

    logic                 w_win_found;
    logic [ID_W-1:0]      w_win_id;
    logic [ID_W-1:0]      w_idx;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_load;
    logic                 w_pop;
    logic [ID_W-1:0]      w_head_id;
    logic [ID_W-1:0]      w_rr_next;

    // Round-robin search: first valid requester at or after the RR pointer, with wrap
    always_comb begin
        w_win_found = 1'b0;
        w_win_id    = '0;
        w_idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = ID_W'((int'(r_rr_ptr) + i) % NUM_REQ);
            if (!w_win_found && req_valid_i[w_idx]) begin
                w_win_found = 1'b1;
                w_win_id    = w_idx;
            end
        end
    end

    assign w_fifo_full  = (r_count == CNT_W'(MAX_OUTSTANDING));
    assign w_fifo_empty = (r_count == '0);
    assign w_head_id    = r_tag_mem[r_rd_ptr];

    // A load needs a free output stage (empty or draining this cycle) and a free tag slot;
    // a pop in the same cycle does not free a slot until the next cycle.
    assign w_load = (!r_cmd_valid || ht_cmd_ready_i) && !w_fifo_full && w_win_found;

    // Results with an empty tag FIFO are a protocol violation: consume and drop them.
    assign w_pop  = ht_res_valid_i && !w_fifo_empty && req_res_ready_i[w_head_id];

    assign w_rr_next = (w_win_id == ID_W'(NUM_REQ - 1)) ? '0 : w_win_id + ID_W'(1);

    // Grant is combinational and asserted only in the load cycle
    always_comb begin
        req_ready_o = '0;
        if (w_load) begin
            req_ready_o[w_win_id] = 1'b1;
        end
    end

    // Result steering toward the requester at the tag FIFO head
    always_comb begin
        req_res_valid_o = '0;
        if (ht_res_valid_i && !w_fifo_empty) begin
            req_res_valid_o[w_head_id] = 1'b1;
        end
        ht_res_ready_o = w_fifo_empty ? 1'b1 : req_res_ready_i[w_head_id];
    end

    assign req_res_o      = ht_res_i;
    assign ht_cmd_o       = r_cmd;
    assign ht_cmd_valid_o = r_cmd_valid;
    assign outstanding_o  = r_count;
    assign err_o          = r_err;

    // Control registers: output-stage valid, RR pointer, FIFO pointers, occupancy, sticky error
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cmd_valid <= 1'b0;
            r_rr_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_load) begin
                r_cmd_valid <= 1'b1;
                r_rr_ptr    <= w_rr_next;
                r_wr_ptr    <= r_wr_ptr + PTR_W'(1);
            end else if (ht_cmd_ready_i) begin
                r_cmd_valid <= 1'b0;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_load, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (ht_res_valid_i && w_fifo_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    // Data registers: winner's command into the output stage, winner's ID into the tag FIFO
    always_ff @(posedge clk_i) begin
        if (w_load) begin
            r_cmd               <= req_cmd_i[w_win_id*CMD_WIDTH +: CMD_WIDTH];
            r_tag_mem[r_wr_ptr] <= w_win_id;
        end
    end

endmodule

// File: tb/tb_ht_cmd_arbiter.sv
// Self-checking bench for ht_cmd_arbiter: randomized requesters and a
// hash-table responder, checked by a queue-based reference model.
`timescale 1ns/1ps
module tb_ht_cmd_arbiter;

    localparam int N     = 4;
    localparam int CMD_W = 25;
    localparam int RES_W = 64;
    localparam int MAXO  = 16;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic [N*CMD_W-1:0] req_cmd_i;
    logic [N-1:0]       req_valid_i;
    logic [N-1:0]       req_ready_o;
    logic [CMD_W-1:0]   ht_cmd_o;
    logic               ht_cmd_valid_o;
    logic               ht_cmd_ready_i;
    logic [RES_W-1:0]   ht_res_i;
    logic               ht_res_valid_i;
    logic               ht_res_ready_o;
    logic [RES_W-1:0]   req_res_o;
    logic [N-1:0]       req_res_valid_o;
    logic [N-1:0]       req_res_ready_i;
    logic [4:0]         outstanding_o;
    logic               err_o;

    ht_cmd_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_cmd_i(req_cmd_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .ht_cmd_o(ht_cmd_o), .ht_cmd_valid_o(ht_cmd_valid_o), .ht_cmd_ready_i(ht_cmd_ready_i),
        .ht_res_i(ht_res_i), .ht_res_valid_i(ht_res_valid_i), .ht_res_ready_o(ht_res_ready_o),
        .req_res_o(req_res_o), .req_res_valid_o(req_res_valid_o), .req_res_ready_i(req_res_ready_i),
        .outstanding_o(outstanding_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Stimulus knobs
    int       p_valid, p_cready, p_rready, p_lat, p_jit;
    logic [N-1:0] p_mask;
    bit       p_hold, inject;

    // Reference model: every command issued but not yet answered, in order
    typedef struct { int id; logic [RES_W-1:0] res; } exp_t;
    exp_t             m_expq[$];
    logic [CMD_W-1:0] m_cmdq[$];
    int               m_rr;
    bit               m_cmd_valid;
    bit               m_err;
    int               m_load_idx;

    // Hash-table responder
    typedef struct { logic [RES_W-1:0] res; int due; } ht_t;
    ht_t ht_q[$];
    int  ht_acc_idx;

    function automatic logic [RES_W-1:0] mkres(input int idx, input logic [CMD_W-1:0] c);
        return {32'(idx), 7'h55, c};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Monitor + reference model, evaluated on the falling edge
    always @(negedge clk_i) begin : monitor
        int           win;
        bit           exp_load;
        logic [N-1:0] exp_rdy;
        logic [CMD_W-1:0] c;
        exp_t         e;
        if (rst_i) begin
            m_expq.delete();
            m_cmdq.delete();
            m_rr        = 0;
            m_cmd_valid = 0;
            m_err       = 0;
            m_load_idx  = 0;
        end else begin
            chk("outstanding", 64'(outstanding_o), 64'(m_expq.size()));
            chk("cmd_valid", 64'(ht_cmd_valid_o), 64'(m_cmd_valid));
            chk("err", 64'(err_o), 64'(m_err));

            exp_load = (!m_cmd_valid || ht_cmd_ready_i) && (m_expq.size() < MAXO) && (req_valid_i != '0);
            win = -1;
            for (int i = 0; i < N; i++)
                if (win < 0 && req_valid_i[(m_rr + i) % N]) win = (m_rr + i) % N;
            exp_rdy = exp_load ? (N'(1) << win) : '0;
            chk("req_ready", 64'(req_ready_o), 64'(exp_rdy));

            if (m_cmd_valid && ht_cmd_ready_i) begin
                if (m_cmdq.size() == 0) chk("cmd_underflow", 64'(1), 64'(0));
                else chk("ht_cmd", 64'(ht_cmd_o), 64'(m_cmdq.pop_front()));
            end

            if (ht_res_valid_i) begin
                if (m_expq.size() == 0) begin
                    chk("bad_res_ready", 64'(ht_res_ready_o), 64'(1));
                    chk("bad_res_valid", 64'(req_res_valid_o), 64'(0));
                    m_err = 1;
                end else begin
                    e = m_expq[0];
                    chk("res_valid", 64'(req_res_valid_o), 64'(N'(1) << e.id));
                    chk("res_ready", 64'(ht_res_ready_o), 64'(req_res_ready_i[e.id]));
                    if (req_res_ready_i[e.id]) begin
                        chk("res_data", req_res_o, e.res);
                        void'(m_expq.pop_front());
                    end
                end
            end else begin
                chk("res_valid_idle", 64'(req_res_valid_o), 64'(0));
            end

            if (exp_load) begin
                c = req_cmd_i[win*CMD_W +: CMD_W];
                m_cmdq.push_back(c);
                e.id  = win;
                e.res = mkres(m_load_idx, c);
                m_expq.push_back(e);
                m_load_idx++;
                m_rr        = (win + 1) % N;
                m_cmd_valid = 1;
            end else if (ht_cmd_ready_i) begin
                m_cmd_valid = 0;
            end
        end
    end

    // Hash table: accepts commands, answers in order after a latency
    always @(negedge clk_i) begin : ht_model
        ht_t h;
        if (rst_i) begin
            ht_q.delete();
            ht_acc_idx = 0;
        end else begin
            if (ht_res_valid_i && ht_res_ready_o && !inject && ht_q.size() > 0)
                void'(ht_q.pop_front());
            if (ht_cmd_valid_o && ht_cmd_ready_i) begin
                h.res = mkres(ht_acc_idx, ht_cmd_o);
                h.due = cyc + p_lat + int'($urandom_range(p_jit, 0));
                ht_q.push_back(h);
                ht_acc_idx++;
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
        cyc++;
        for (int r = 0; r < N; r++) begin
            req_valid_i[r] = !rst_i && p_mask[r] && (int'($urandom_range(99, 0)) < p_valid);
            req_cmd_i[r*CMD_W +: CMD_W] = CMD_W'($urandom());
            req_res_ready_i[r] = (int'($urandom_range(99, 0)) < p_rready);
        end
        ht_cmd_ready_i = (int'($urandom_range(99, 0)) < p_cready);
        if (rst_i) begin
            ht_res_valid_i = 1'b0;
            ht_res_i       = '0;
        end else if (inject) begin
            ht_res_valid_i = 1'b1;
            ht_res_i       = 64'hDEAD_BEEF_0BAD_F00D;
        end else if (!p_hold && ht_q.size() > 0 && ht_q[0].due <= cyc) begin
            ht_res_valid_i = 1'b1;
            ht_res_i       = ht_q[0].res;
        end else begin
            ht_res_valid_i = 1'b0;
            ht_res_i       = '0;
        end
    endtask

    task automatic knobs(input int v, input int cr, input int rr, input int lat, input int jit,
                         input logic [N-1:0] mask);
        p_valid = v; p_cready = cr; p_rready = rr; p_lat = lat; p_jit = jit; p_mask = mask;
    endtask

    initial begin
        rst_i = 1'b1; req_cmd_i = '0; req_valid_i = '0; ht_cmd_ready_i = 1'b0;
        ht_res_i = '0; ht_res_valid_i = 1'b0; req_res_ready_i = '0;
        p_hold = 0; inject = 0;
        knobs(0, 100, 100, 3, 0, 4'b1111);
        repeat (3) step();
        rst_i = 1'b0;
        // Reset values with no requests pending
        chk("rst_req_ready", 64'(req_ready_o), 64'(0));
        chk("rst_cmd_valid", 64'(ht_cmd_valid_o), 64'(0));
        chk("rst_outstanding", 64'(outstanding_o), 64'(0));
        chk("rst_err", 64'(err_o), 64'(0));
        chk("rst_res_valid", 64'(req_res_valid_o), 64'(0));

        // All requesters valid, table always ready, results 3 cycles later
        knobs(100, 100, 100, 3, 0, 4'b1111);
        repeat (60) step();

        // Only requester 2, five commands
        knobs(0, 100, 100, 3, 0, 4'b0100);
        repeat (10) step();
        knobs(100, 100, 100, 3, 0, 4'b0100);
        repeat (5) step();
        knobs(0, 100, 100, 3, 0, 4'b0100);
        repeat (20) step();

        // General random traffic with command stalls and result backpressure
        knobs(60, 50, 60, 1, 6, 4'b1111);
        repeat (1500) step();

        // Fill to MAX_OUTSTANDING with results withheld
        p_hold = 1;
        knobs(100, 100, 100, 1, 0, 4'b1111);
        repeat (40) step();
        chk("full_outstanding", 64'(outstanding_o), 64'(MAXO));
        chk("full_req_ready", 64'(req_ready_o), 64'(0));
        p_hold = 0;
        repeat (300) step();

        // Heavy head-of-line blocking
        knobs(70, 80, 20, 1, 3, 4'b1111);
        repeat (800) step();

        // Reset in the middle of traffic
        rst_i = 1'b1;
        repeat (2) step();
        rst_i = 1'b0;
        knobs(60, 70, 60, 2, 4, 4'b1111);
        repeat (300) step();

        // Result with an empty tag FIFO
        rst_i = 1'b1;
        knobs(0, 100, 100, 1, 0, 4'b1111);
        repeat (2) step();
        rst_i = 1'b0;
        step();
        inject = 1;
        step();
        chk("inj_res_ready", 64'(ht_res_ready_o), 64'(1));
        chk("inj_res_valid", 64'(req_res_valid_o), 64'(0));
        inject = 0;
        step();
        chk("inj_err_set", 64'(err_o), 64'(1));
        repeat (3) step();
        chk("inj_err_sticky", 64'(err_o), 64'(1));
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        step();
        chk("inj_err_cleared", 64'(err_o), 64'(0));

        // Final traffic and bounded drain
        knobs(60, 70, 70, 1, 4, 4'b1111);
        repeat (300) step();
        knobs(0, 100, 100, 1, 0, 4'b1111);
        for (int k = 0; k < 500 && (m_expq.size() != 0 || ht_q.size() != 0); k++) step();
        chk("drain_remaining", 64'(m_expq.size()), 64'(0));
        chk("drain_outstanding", 64'(outstanding_o), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
